// File: rtl/jk_bank_ctrl_pkg.sv
// Shared definitions for the JK bank controller: op codes, FSM states and
// the command-length width.
package jk_bank_ctrl_pkg;

  localparam int LEN_W = 8;

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_CLEAR   = 3'd2;
  localparam logic [2:0] OP_INC     = 3'd3;
  localparam logic [2:0] OP_DEC     = 3'd4;
  localparam logic [2:0] OP_SHL     = 3'd5;
  localparam logic [2:0] OP_TOGGLE  = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // LOAD and CLEAR always perform exactly one update regardless of length.
  function automatic logic op_is_single(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One bank bit: JK flip-flop with asynchronous active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_o <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b00:   q_o <= q_o;
        2'b01:   q_o <= 1'b0;
        2'b10:   q_o <= 1'b1;
        default: q_o <= ~q_o;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of WIDTH JK cells: latches a command,
// drives per-bit J/K for the requested number of updates, then pulses done.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a command; all cells see J=K=0
// RUN     | one bank update per cycle until count exhausted or abort
// DONE    | single-cycle completion pulse, then back to IDLE
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;

  logic               accept;
  logic               upd;
  logic [WIDTH-1:0]   inc_t, dec_t, shl_in;
  logic [WIDTH-1:0]   jv, kv;

  assign accept = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (cmd_op == OP_ILLEGAL) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // A count of 1 means this edge performs the final update.
        if (abort || (cnt_q <= 8'd1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    upd       = (state_q == ST_RUN) && !abort && (cnt_q != '0);
  end

  // ----------------------------------------------------- command datapath
  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    wrap_d = upd && (((op_q == OP_INC) && (&q)) || ((op_q == OP_DEC) && (~|q)));
    if (accept) begin
      op_d   = cmd_op;
      data_d = cmd_data;
      if (cmd_op == OP_ILLEGAL) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else if (op_is_single(cmd_op)) begin
        cnt_d = 8'd1;
      end else begin
        cnt_d = cmd_len;
      end
    end else if (upd) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_HOLD;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  assign err  = err_q;
  assign wrap = wrap_q;

  // ------------------------------------------------------ J/K decode
  // Prefix ANDs: bit i toggles on INC when all lower bits are 1, on DEC
  // when all lower bits are 0.
  always_comb begin
    inc_t    = '0;
    dec_t    = '0;
    inc_t[0] = 1'b1;
    dec_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_t[i] = inc_t[i-1] & q[i-1];
      dec_t[i] = dec_t[i-1] & ~q[i-1];
    end
  end

  assign shl_in = {q[WIDTH-2:0], data_q[0]};

  always_comb begin
    jv = '0;
    kv = '0;
    if (upd) begin
      case (op_q)
        OP_LOAD: begin
          jv = data_q;
          kv = ~data_q;
        end
        OP_CLEAR: begin
          jv = '0;
          kv = '1;
        end
        OP_INC: begin
          jv = inc_t;
          kv = inc_t;
        end
        OP_DEC: begin
          jv = dec_t;
          kv = dec_t;
        end
        OP_SHL: begin
          jv = shl_in;
          kv = ~shl_in;
        end
        OP_TOGGLE: begin
          jv = data_q;
          kv = data_q;
        end
        default: begin
          jv = '0;
          kv = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------ bank
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .j_i     (jv[gi]),
      .k_i     (kv[gi]),
      .q_o     (q[gi])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed and random commands compared
// against an arithmetic model of the bank.
module tb_jk_bank_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [7:0]   cmd_len;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         err;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] mq;
  logic         err_exp;

  jk_bank_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bank behaviour of one update, in plain arithmetic.
  function automatic void step(input logic [2:0] op, input logic [W-1:0] d,
                               input logic [W-1:0] cur,
                               output logic [W-1:0] nq, output logic w);
    w = 1'b0;
    case (op)
      3'd1:    nq = d;
      3'd2:    nq = '0;
      3'd3: begin
        nq = W'((int'(cur) + 1) % (1 << W));
        w  = (int'(cur) == (1 << W) - 1);
      end
      3'd4: begin
        nq = W'((int'(cur) + (1 << W) - 1) % (1 << W));
        w  = (cur == '0);
      end
      3'd5:    nq = W'((int'(cur) * 2 + int'(d[0])) % (1 << W));
      3'd6:    nq = cur ^ d;
      default: nq = cur;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"},     32'(q),         32'(0));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(1));
    chk({tag, "_busy"},  32'(busy),      32'(0));
    chk({tag, "_done"},  32'(done),      32'(0));
    chk({tag, "_wrap"},  32'(wrap),      32'(0));
    chk({tag, "_err"},   32'(err),       32'(0));
  endtask

  // Issue one command from IDLE (at a negedge) and check every cycle through
  // the return to IDLE. abort_k > 0 raises abort for the edge of update k.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] dat,
                       input logic [7:0] len, input int abort_k);
    int           n_upd, eff, dedge, ab;
    logic [W-1:0] qs[$];
    logic         ws[$];
    logic [W-1:0] nq;
    logic         w;

    n_upd = (op == 3'd1 || op == 3'd2) ? 1 : ((op == 3'd7) ? 0 : int'(len));
    eff   = n_upd;
    dedge = (op == 3'd7) ? 0 : ((n_upd == 0) ? 1 : n_upd);
    ab    = (abort_k > 0 && abort_k <= n_upd) ? abort_k : 0;
    if (ab > 0) begin
      eff   = ab - 1;
      dedge = ab;
    end
    qs.push_back(mq);
    ws.push_back(1'b0);
    for (int k = 1; k <= eff; k++) begin
      step(op, dat, qs[k-1], nq, w);
      qs.push_back(nq);
      ws.push_back(w);
    end
    if (op == 3'd7) err_exp = 1'b1;

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = dat;
    cmd_len   = len;
    abort     = 1'($urandom_range(0, 1));  // ignored while IDLE
    @(posedge clk);
    @(negedge clk);

    for (int c = 0; c <= dedge + 1; c++) begin
      if (c < dedge) begin
        chk("busy_run",   32'(busy),      32'(1));
        chk("done_run",   32'(done),      32'(0));
        chk("ready_run",  32'(cmd_ready), 32'(0));
      end else if (c == dedge) begin
        chk("busy_done",  32'(busy),      32'(0));
        chk("done_pulse", 32'(done),      32'(1));
        chk("ready_done", 32'(cmd_ready), 32'(0));
      end else begin
        chk("busy_idle",  32'(busy),      32'(0));
        chk("done_idle",  32'(done),      32'(0));
        chk("ready_idle", 32'(cmd_ready), 32'(1));
      end
      chk("q",    32'(q),    32'(qs[(c < eff) ? c : eff]));
      chk("wrap", 32'(wrap), 32'((c >= 1 && c <= eff) ? ws[c] : 1'b0));
      chk("err",  32'(err),  32'(err_exp));

      abort = (c + 1 == ab) || (c == dedge && $urandom_range(0, 1) == 1);
      if (c <= dedge) begin
        // Garbage on the command inputs must not be taken outside IDLE.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = W'($urandom);
        cmd_len   = 8'($urandom_range(0, 255));
        @(posedge clk);
        @(negedge clk);
      end else begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
      end
    end
    mq = qs[eff];
  endtask

  initial begin
    int op_r, len_r, ab_r;
    logic [2:0] rop;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    cmd_len   = 8'd0;
    abort     = 1'b0;
    mq        = '0;
    err_exp   = 1'b0;

    #1;
    check_reset_outputs("rst_t1");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_clk");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Directed scenarios.
    do_op(3'd1, 8'hA5, 8'd9, 0);         // LOAD ignores len
    do_op(3'd1, 8'hFD, 8'd0, 0);
    do_op(3'd3, 8'h00, 8'd4, 0);         // INC FD -> FE FF 00 01
    do_op(3'd2, 8'h5A, 8'd7, 0);         // CLEAR
    do_op(3'd4, 8'h00, 8'd1, 0);         // DEC 00 -> FF
    do_op(3'd1, 8'h01, 8'd0, 0);
    do_op(3'd5, 8'h01, 8'd3, 0);         // SHL -> 03 07 0F
    do_op(3'd2, 8'h00, 8'd0, 0);
    do_op(3'd6, 8'h0F, 8'd6, 3);         // TOGGLE aborted before 3rd update
    do_op(3'd7, 8'h33, 8'd5, 0);         // illegal
    do_op(3'd0, 8'hFF, 8'd0, 0);         // HOLD len=0
    do_op(3'd4, 8'h00, 8'd0, 0);         // DEC len=0
    do_op(3'd3, 8'h00, 8'd2, 1);         // abort on first update

    // Random commands; bias toward wraps by occasionally preloading extremes.
    for (int n = 0; n < 60; n++) begin
      op_r  = int'($urandom_range(0, 7));
      len_r = int'($urandom_range(0, 9));
      rop   = 3'(op_r);
      if ((rop == 3'd3 || rop == 3'd4) && $urandom_range(0, 2) == 0) begin
        do_op(3'd1, (rop == 3'd3) ? 8'hFE : 8'h01, 8'd0, 0);
      end
      ab_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      do_op(rop, W'($urandom), 8'(len_r), ab_r);
    end

    // Asynchronous reset in the middle of a long INC.
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_data  = '0;
    cmd_len   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("long_busy", 32'(busy), 32'(1));
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    mq      = '0;
    err_exp = 1'b0;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    do_op(3'd1, 8'h3C, 8'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
